// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control FSM.
// MULTICYCLE_CONTROL_TRAP_EN adds the sticky TRAP state.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,
        ST_EXEC_I = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        , ST_TRAP = 4'd10
`endif
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_RTYPE,
        CL_ITYPE,
        CL_BRANCH,
        CL_OTHER
    } iclass_e;

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       pcSrc;
        logic       retire;
    } ctl_t;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Maps the IR opcode field to an instruction class.
module opcode_class
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode_i,
    output iclass_e    iclass_o
);

    always_comb begin
        iclass_o = CL_OTHER;
        unique case (opcode_i)
            OP_LOAD:   iclass_o = CL_LOAD;
            OP_STORE:  iclass_o = CL_STORE;
            OP_RTYPE:  iclass_o = CL_RTYPE;
            OP_ITYPE:  iclass_o = CL_ITYPE;
            OP_BRANCH: iclass_o = CL_BRANCH;
            default:   iclass_o = CL_OTHER;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM; MULTICYCLE_CONTROL_TRAP_EN
// turns unknown opcodes into a sticky TRAP instead of a nop.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       memtoReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       pcSrc,
    output logic       retire,
    output logic [3:0] state,
    output logic       illegal
);

    state_e  state_q, state_d;
    iclass_e iclass;
    ctl_t    ctl;

    opcode_class u_class (
        .opcode_i (opcode),
        .iclass_o (iclass)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                ctl.memRead = 1'b1;
                ctl.aluSrcB = SRCB_FOUR;
                ctl.aluOp   = ALU_ADD;
                ctl.irWrite = memReady;
                ctl.pcWrite = memReady;
                if (memReady) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ctl.aluSrcB = SRCB_BOFF;
                ctl.aluOp   = ALU_ADD;
                unique case (iclass)
                    CL_LOAD, CL_STORE: state_d = ST_MEMADR;
                    CL_RTYPE:          state_d = ST_EXEC_R;
                    CL_ITYPE:          state_d = ST_EXEC_I;
                    CL_BRANCH:         state_d = ST_BRANCH;
                    default: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        ctl.retire = 1'b1;
                        state_d    = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEMADR: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_IMM;
                ctl.aluOp   = ALU_ADD;
                state_d = (iclass == CL_LOAD) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                ctl.memRead = 1'b1;
                ctl.iorD    = 1'b1;
                if (memReady) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctl.regWrite = 1'b1;
                ctl.memtoReg = 1'b1;
                ctl.retire   = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_MEMWR: begin
                ctl.memWrite = 1'b1;
                ctl.iorD     = 1'b1;
                ctl.retire   = memReady;
                if (memReady) state_d = ST_FETCH;
            end
            ST_EXEC_R: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_RS2;
                ctl.aluOp   = ALU_FUNCT;
                state_d     = ST_ALUWB;
            end
            ST_EXEC_I: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_IMM;
                ctl.aluOp   = ALU_FUNCT;
                state_d     = ST_ALUWB;
            end
            ST_ALUWB: begin
                ctl.regWrite = 1'b1;
                ctl.retire   = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = SRCB_RS2;
                ctl.aluOp   = ALU_SUB;
                ctl.pcSrc   = PCSRC_ALUOUT;
                ctl.pcWrite = ~zero;
                ctl.retire  = 1'b1;
                state_d     = ST_FETCH;
            end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset masks every control so nothing fires while held.
    assign {pcWrite, irWrite, iorD, memRead, memWrite, memtoReg,
            regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, retire}
        = reset ? ctl : '0;

    assign state = state_q;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | (state_d == ST_TRAP);

    always_ff @(posedge clock) begin
        if (!reset) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q & reset;
`else
    assign illegal = 1'b0;
`endif

endmodule
